game_ui_sequencer: RTL and testbench
====================================

Name: game_ui_sequencer

Overview:
- Controller that walks the UI-configuration ROM reader entry by entry.
- Drives the reader's address and sync handshake, and captures each entry's scheduled next time.
- Issues one apply pulse per valid entry so downstream health-bar/character registers latch the reader outputs.
- Holds off the next fetch until the game clock reaches that entry's scheduled time; stops on the end-marker entry, an address overflow or a handshake timeout.

Parameters:
- ADDR_WIDTH, 10, width of the ROM entry address.
- MAXIMUM_TIMES, 30, width of the game time base and of scheduled times.
- FETCH_TIMEOUT, 16, cycles allowed in FETCH for rom_update before an error is flagged (must be ≥4).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse: begin the sequence at entry 0 (honoured only in IDLE, DONE or ERROR)
- pause  in  1  level: freeze time-wait progression
- current_time  in  MAXIMUM_TIMES  game runtime time base
- rom_update  in  1  reader's "entry loaded, next time valid" flag
- rom_next_time  in  MAXIMUM_TIMES  reader's computed next time
- rom_is_end  in  1  reader's end-marker flag
- rom_addr  out  ADDR_WIDTH  entry address to reader
- rom_sync  out  1  sync level to reader: 1 = hold/acknowledge, 0 = fetch
- apply_ui  out  1  one-cycle pulse: latch reader config outputs
- entry_index  out  ADDR_WIDTH  address of the entry last applied
- busy  out  1  high in FETCH/ACK/WAIT
- done  out  1  level: sequence ended (end marker or overflow)
- overflow  out  1  level: done reached by address exhaustion
- error  out  1  level: FETCH timeout

Behaviour:
- Reset values: rom_addr=0, rom_sync=1, apply_ui=0, entry_index=0, busy=0, done=0, overflow=0, error=0; state=IDLE; internal target_time=0, timeout counter=0.
- IDLE:
  - rom_sync=1.
  - On start: rom_addr←0; clear done, overflow and error; go to FETCH.
- FETCH:
  - rom_sync=0; the timeout counter increments each cycle.
  - On rom_update=1: target_time←rom_next_time, end_flag←rom_is_end; go to ACK.
  - If the counter reaches FETCH_TIMEOUT first: error←1, go to ERROR.
- ACK:
  - One cycle, rom_sync=1, clearing the reader's update state.
  - If end_flag: done←1, go to DONE, no apply_ui.
  - Otherwise: apply_ui=1 this cycle, entry_index←rom_addr, go to WAIT.
- WAIT:
  - rom_sync=1.
  - When pause=0 and current_time ≥ target_time (unsigned compare, no wrap handling):
    - if rom_addr == 2^ADDR_WIDTH−1: done←1, overflow←1, go to DONE;
    - else rom_addr←rom_addr+1, reset the timeout counter, go to FETCH.
  - While pause=1: hold state and rom_addr; the comparison is ignored.
- DONE and ERROR:
  - rom_sync=1; outputs hold.
  - start restarts the sequence as from IDLE.
- start while busy: ignored.
- pause has no effect in FETCH or ACK, so a handshake always completes.
- Reset mid-sequence returns to IDLE next cycle with rom_sync=1; no apply_ui is emitted.
- Throughput: the minimum time from rom_update to the next FETCH entry is 3 cycles (ACK, WAIT with time already met, then FETCH).
- rom_sync toggles only on state transitions: it is registered and glitch-free.

Decomposition:
- Shared package (game_ui_pkg):
  - state encoding localparams: IDLE, FETCH, ACK, WAIT, DONE, ERROR;
  - default FETCH_TIMEOUT;
  - the end-marker definition (all-ones entry), shared with the reader.
- One natural sub-module, game_ui_time_gate: registered "current_time ≥ target_time and not paused" comparator with target load. This keeps the wide compare off the FSM critical path.
- Everything else stays in one file.

Test Plan:
- Reset, then start with entry 0 wait_time=5 and current_time=100: expect the reader to report next_time=150, apply_ui exactly once with entry_index=0, and rom_addr to advance to 1 only when current_time reaches 150.
- Entry 1 is all-ones: after entry 0 completes, FETCH→ACK sets done=1, produces no second apply_ui, and rom_sync stays 1.
- Pause=1 asserted in WAIT while current_time passes target by 20: rom_addr stays 0; releasing pause gives FETCH within 2 cycles.
- Stub rom_update held at 0: error=1 after exactly 16 FETCH cycles; a subsequent start restarts from rom_addr=0 with error cleared.
- ADDR_WIDTH=2, no end marker: after 4 applies with entry_index 0..3, done=1 and overflow=1; rom_addr does not wrap.
- Reset asserted in WAIT: next cycle the block is in IDLE with all outputs at reset values; start resumes at entry 0.

Source files
------------

// File: rtl/game_ui_pkg.sv
// Shared definitions for the UI-configuration ROM sequencer and its reader.
package game_ui_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ACK   = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  localparam int DEFAULT_FETCH_TIMEOUT = 16;

  // A ROM entry of all ones terminates the sequence.
  localparam int ENTRY_WIDTH = 32;
  localparam logic [ENTRY_WIDTH-1:0] END_MARKER = '1;

  function automatic logic is_end_marker(input logic [ENTRY_WIDTH-1:0] entry);
    return entry == END_MARKER;
  endfunction

endpackage

// File: rtl/game_ui_sequencer_if.sv
// Address/sync handshake between the sequencer (master) and the ROM reader (slave).
interface game_ui_sequencer_if #(
  parameter int ADDR_WIDTH    = 10,
  parameter int MAXIMUM_TIMES = 30
);
  logic [ADDR_WIDTH-1:0]    rom_addr;
  logic                     rom_sync;
  logic                     rom_update;
  logic [MAXIMUM_TIMES-1:0] rom_next_time;
  logic                     rom_is_end;

  modport master (
    output rom_addr, rom_sync,
    input  rom_update, rom_next_time, rom_is_end
  );

  modport slave (
    input  rom_addr, rom_sync,
    output rom_update, rom_next_time, rom_is_end
  );
endinterface

// File: rtl/game_ui_time_gate.sv
// Registered "time reached and not paused" flag against a loadable target time.
// One cycle of latency: met reflects current_time/pause of the previous cycle.
module game_ui_time_gate #(
  parameter int MAXIMUM_TIMES = 30
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [MAXIMUM_TIMES-1:0] load_time,
  input  logic [MAXIMUM_TIMES-1:0] current_time,
  input  logic                     pause,
  output logic                     met
);
  logic [MAXIMUM_TIMES-1:0] target_time;

  always_ff @(posedge clk) begin
    if (reset) begin
      target_time <= '0;
      met         <= 1'b0;
    end else begin
      if (load) target_time <= load_time;
      // Plain unsigned compare: the time base is not expected to wrap.
      met <= !pause && (current_time >= target_time);
    end
  end
endmodule

// File: rtl/game_ui_sequencer.sv
// Walks the UI ROM reader entry by entry, one apply pulse per entry, pacing fetches on game time.
// rom_update to next FETCH is 3 cycles minimum; pause stalls only the time wait, never a handshake.
module game_ui_sequencer
  import game_ui_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int MAXIMUM_TIMES = 30,
  parameter int FETCH_TIMEOUT = DEFAULT_FETCH_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     pause,
  input  logic [MAXIMUM_TIMES-1:0] current_time,
  game_ui_sequencer_if.master      rom,
  output logic                     apply_ui,
  output logic [ADDR_WIDTH-1:0]    entry_index,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic                     error
);
  localparam int                    CNT_W     = $clog2(FETCH_TIMEOUT);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(FETCH_TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  sync;
  logic                  end_flag;
  logic [CNT_W-1:0]      timeout_cnt;
  logic                  time_met;
  logic                  load_target;

  assign load_target  = (state == FETCH) && rom.rom_update;
  assign rom.rom_addr = addr;
  assign rom.rom_sync = sync;

  game_ui_time_gate #(
    .MAXIMUM_TIMES(MAXIMUM_TIMES)
  ) u_time_gate (
    .clk          (clk),
    .reset        (reset),
    .load         (load_target),
    .load_time    (rom.rom_next_time),
    .current_time (current_time),
    .pause        (pause),
    .met          (time_met)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= '0;
      sync        <= 1'b1;
      apply_ui    <= 1'b0;
      entry_index <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      error       <= 1'b0;
      end_flag    <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      apply_ui <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state       <= FETCH;
            addr        <= '0;
            sync        <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            overflow    <= 1'b0;
            error       <= 1'b0;
            timeout_cnt <= '0;
          end
        end
        FETCH: begin
          if (rom.rom_update) begin
            // Apply is decided here so the pulse lines up with the ACK cycle itself.
            state    <= ACK;
            sync     <= 1'b1;
            end_flag <= rom.rom_is_end;
            apply_ui <= !rom.rom_is_end;
            if (!rom.rom_is_end) entry_index <= addr;
          end else if (timeout_cnt == CNT_LAST) begin
            state <= ERROR;
            sync  <= 1'b1;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        ACK: begin
          if (end_flag) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // The gate lags a cycle, so the live pause also blocks the step.
          if (time_met && !pause) begin
            if (addr == LAST_ADDR) begin
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              overflow <= 1'b1;
            end else begin
              state       <= FETCH;
              sync        <= 1'b0;
              addr        <= addr + 1'b1;
              timeout_cnt <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          sync  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_game_ui_sequencer.sv
// Scoreboard bench: directed scenarios plus randomised runs against a ROM reader stub.
`timescale 1ns/1ps
module tb_game_ui_sequencer;
  localparam int AW      = 2;
  localparam int TW      = 30;
  localparam int TIMEOUT = 16;
  localparam logic [2:0] END_DONE = 3'b100;
  localparam logic [2:0] END_OVF  = 3'b110;
  localparam logic [2:0] END_ERR  = 3'b001;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic [TW-1:0] current_time = '0;
  logic          apply_ui, busy, done, overflow, error;
  logic [AW-1:0] entry_index;

  int            checks = 0;
  int            errors = 0;
  int            time_step = 0;
  int            lat = 0;
  bit            stall = 1'b0;
  logic [TW-1:0] last_target = '0;
  logic [31:0]   rom_entry [4];
  int            exp_apply [$];
  logic [2:0]    exp_end [$];

  game_ui_sequencer_if #(.ADDR_WIDTH(AW), .MAXIMUM_TIMES(TW)) rom_bus ();

  game_ui_sequencer #(
    .ADDR_WIDTH(AW), .MAXIMUM_TIMES(TW), .FETCH_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause),
    .current_time(current_time), .rom(rom_bus),
    .apply_ui(apply_ui), .entry_index(entry_index), .busy(busy),
    .done(done), .overflow(overflow), .error(error)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Expected outcome of one run, straight from the ROM contents.
  task automatic expect_run(input bit stalled);
    if (stalled) begin
      exp_end.push_back(END_ERR);
      return;
    end
    for (int i = 0; i < 4; i++) begin
      if (rom_entry[i] == '1) begin
        exp_end.push_back(END_DONE);
        return;
      end
      exp_apply.push_back(i);
    end
    exp_end.push_back(END_OVF);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    current_time = current_time + TW'(time_step);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_addr"}, 64'(rom_bus.rom_addr), 0);
    check({tag, "_sync"}, 64'(rom_bus.rom_sync), 1);
    check({tag, "_apply"}, 64'(apply_ui), 0);
    check({tag, "_index"}, 64'(entry_index), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_flags"}, 64'({done, overflow, error}), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_addr_zero", 64'(rom_bus.rom_addr), 0);
    check("start_flags_clear", 64'({done, overflow, error}), 0);
    check("start_busy", 64'(busy), 1);
  endtask

  task automatic wait_apply();
    int n = 0;
    while (!apply_ui && n < 200) begin
      tick();
      n++;
    end
    check("apply_seen", 64'(apply_ui), 1);
  endtask

  task automatic drive_until_end(input int pause_pct);
    int n = 0;
    pause = 1'b0;
    while (!(done || error) && n < 3000) begin
      if (int'($urandom_range(99)) < pause_pct) pause = ~pause;
      start = busy && ($urandom_range(15) == 0);
      tick();
      n++;
    end
    start = 1'b0;
    pause = 1'b0;
    check("run_terminates", 64'(done | error), 1);
    repeat (3) begin
      tick();
      check("end_sync_held", 64'(rom_bus.rom_sync), 1);
    end
    check("end_busy_clear", 64'(busy), 0);
    check("apply_queue_drained", 64'(exp_apply.size()), 0);
    check("end_queue_drained", 64'(exp_end.size()), 0);
    exp_apply.delete();
    exp_end.delete();
  endtask

  // ROM reader stub: answers a fetch after lat cycles, next_time = now + 10*wait.
  initial begin : reader
    int wait_cyc;
    wait_cyc = 0;
    rom_bus.rom_update    = 1'b0;
    rom_bus.rom_next_time = '0;
    rom_bus.rom_is_end    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset || rom_bus.rom_sync) begin
        rom_bus.rom_update = 1'b0;
        wait_cyc = 0;
      end else if (!rom_bus.rom_update && !stall) begin
        if (wait_cyc >= lat) begin
          rom_bus.rom_next_time = current_time + TW'(10 * rom_entry[rom_bus.rom_addr][7:0]);
          rom_bus.rom_is_end    = game_ui_pkg::is_end_marker(rom_entry[rom_bus.rom_addr]);
          rom_bus.rom_update    = 1'b1;
          last_target           = rom_bus.rom_next_time;
        end else begin
          wait_cyc++;
        end
      end
    end
  end

  initial begin : monitor
    logic prev_apply, prev_busy, prev_term, term;
    logic [AW-1:0] prev_addr;
    int fetch_cnt, met_cnt;
    prev_apply = 1'b0;
    prev_busy  = 1'b0;
    prev_term  = 1'b0;
    prev_addr  = '0;
    fetch_cnt  = 0;
    met_cnt    = 0;
    forever begin
      @(negedge clk);
      term = done | error;
      if (!reset) begin
        if (apply_ui) begin
          check("apply_single_cycle", 64'(prev_apply), 0);
          check("apply_expected", 64'(exp_apply.size() > 0), 1);
          if (exp_apply.size() > 0) check("apply_index", 64'(entry_index), 64'(exp_apply.pop_front()));
        end
        if (term && !prev_term) begin
          check("end_expected", 64'(exp_end.size() > 0), 1);
          if (exp_end.size() > 0) check("end_flags", 64'({done, overflow, error}), 64'(exp_end.pop_front()));
          if (error) check("timeout_fetch_cycles", 64'(fetch_cnt), TIMEOUT);
          check("end_sync", 64'(rom_bus.rom_sync), 1);
        end
        if (busy && prev_busy && rom_bus.rom_addr != prev_addr) begin
          check("advance_step", 64'(rom_bus.rom_addr), 64'(prev_addr) + 1);
          check("advance_after_time_met", 64'(met_cnt >= 1 && met_cnt <= 2), 1);
        end
      end
      // Consecutive held cycles with the wait condition satisfied and not paused.
      if (!reset && busy && rom_bus.rom_sync && !pause && current_time >= last_target) met_cnt++;
      else met_cnt = 0;
      if (met_cnt > 2) check("wait_overdue", 64'(met_cnt), 2);
      fetch_cnt  = (!reset && busy && !rom_bus.rom_sync) ? fetch_cnt + 1 : 0;
      prev_apply = apply_ui;
      prev_busy  = busy;
      prev_term  = term;
      prev_addr  = rom_bus.rom_addr;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    for (int i = 0; i < 4; i++) rom_entry[i] = '0;
    repeat (2) tick();
    check_idle("reset");
    reset = 1'b0;

    // Entry 0 waits until 150, entry 1 is the end marker.
    rom_entry[0] = 32'd5;
    rom_entry[1] = '1;
    current_time = TW'(100);
    time_step = 0;
    lat = 1;
    expect_run(1'b0);
    pulse_start();
    repeat (30) tick();
    check("hold_before_target_addr", 64'(rom_bus.rom_addr), 0);
    check("hold_before_target_busy", 64'(busy), 1);
    time_step = 1;
    drive_until_end(0);

    // Pause held while time overshoots the target.
    rom_entry[0] = 32'd2;
    rom_entry[1] = '1;
    current_time = TW'(1000);
    time_step = 0;
    expect_run(1'b0);
    pulse_start();
    wait_apply();
    pause = 1'b1;
    tick();
    current_time = last_target + TW'(20);
    repeat (10) tick();
    check("pause_hold_addr", 64'(rom_bus.rom_addr), 0);
    check("pause_hold_sync", 64'(rom_bus.rom_sync), 1);
    pause = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (rom_bus.rom_sync && n < 6);
    check("pause_release_within_2", 64'(n <= 2), 1);
    time_step = 1;
    drive_until_end(0);

    // Reader never answers.
    stall = 1'b1;
    expect_run(1'b1);
    pulse_start();
    drive_until_end(0);
    stall = 1'b0;

    // No end marker: address exhaustion.
    rom_entry[0] = 32'd1;
    rom_entry[1] = 32'd0;
    rom_entry[2] = 32'd3;
    rom_entry[3] = 32'd2;
    time_step = 2;
    expect_run(1'b0);
    pulse_start();
    drive_until_end(0);
    check("overflow_no_wrap_addr", 64'(rom_bus.rom_addr), 3);
    check("overflow_flags_hold", 64'({done, overflow, error}), 64'(END_OVF));

    // Reset while waiting, then restart.
    rom_entry[0] = 32'd5;
    rom_entry[1] = 32'd5;
    rom_entry[2] = '1;
    current_time = TW'(200);
    time_step = 0;
    expect_run(1'b0);
    pulse_start();
    wait_apply();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_idle("reset_in_wait");
    exp_apply.delete();
    exp_end.delete();
    reset = 1'b0;
    tick();
    time_step = 1;
    expect_run(1'b0);
    pulse_start();
    drive_until_end(0);

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 4; i++)
        rom_entry[i] = ($urandom_range(4) == 0) ? '1 : 32'($urandom_range(7));
      time_step = int'($urandom_range(3, 1));
      lat = int'($urandom_range(4));
      stall = ($urandom_range(9) == 0);
      expect_run(stall);
      pulse_start();
      drive_until_end(int'($urandom_range(20)));
      stall = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
